// File: rtl/modn_stream_checker.sv
// modn_stream_checker: running remainder of a framed bit stream modulo DIVISOR.
// W_IN bits are consumed per valid beat, either MSB-first or LSB-first. Each frame
// result is captured when its last beat arrives.
//
// Optional feature macro: MODN_HIT_CNT_EN. When it is defined, the hit_cnt output is
// added. hit_cnt is a saturating count of completed frames that were divisible.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   beat qualifier
//   in_bits    data beat (W_IN bits)
//   in_last    final beat of frame (qualified by in_valid)
//   clear      abort current frame; next beat starts from zero
//   hit_cnt    divisible-frame counter (only with MODN_HIT_CNT_EN)
//   y          running prefix divisible by DIVISOR
//   rem        running remainder
//   busy       frame in progress
//   done       one-cycle pulse after an in_last beat
//   frame_div  divisibility of the last completed frame
//   frame_rem  remainder of the last completed frame
module modn_stream_checker #(
  parameter int unsigned DIVISOR   = 5,
  parameter int unsigned W_IN      = 1,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned REM_W    = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W_IN-1:0]  in_bits,
  input  logic             in_last,
  input  logic             clear,
`ifdef MODN_HIT_CNT_EN
  output logic [15:0]      hit_cnt,
`endif
  output logic             y,
  output logic [REM_W-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             frame_div,
  output logic [REM_W-1:0] frame_rem
);

  localparam logic [REM_W:0] DivW = (REM_W+1)'(DIVISOR);

  typedef enum logic {StIdle, StAccum} state_e;

  state_e           state_q;
  logic [REM_W-1:0] rem_q, weight_q, frame_rem_q;
  logic             y_q, done_q, frame_div_q;
`ifdef MODN_HIT_CNT_EN
  logic [15:0]      hit_cnt_q;
`endif

  logic             restart;
  logic [REM_W-1:0] base_rem, base_w, rem_next, weight_next;
  // One extra bit holds 2r+b or r+w, which are both below 2*DIVISOR.
  logic [REM_W:0]   acc, w;

  always_comb begin
    restart  = (state_q == StIdle) || clear;
    base_rem = restart ? '0 : rem_q;
    base_w   = restart ? REM_W'(1) : weight_q;
    acc      = {1'b0, base_rem};
    w        = {1'b0, base_w};
    if (MSB_FIRST) begin
      for (int i = W_IN - 1; i >= 0; i--) begin
        acc = {acc[REM_W-1:0], in_bits[i]};
        if (acc >= DivW) acc = acc - DivW;
      end
    end else begin
      // Add the weight of each set bit. Then double the weight for the next bit position.
      for (int i = 0; i < W_IN; i++) begin
        if (in_bits[i]) begin
          acc = acc + w;
          if (acc >= DivW) acc = acc - DivW;
        end
        w = {w[REM_W-1:0], 1'b0};
        if (w >= DivW) w = w - DivW;
      end
    end
    rem_next    = acc[REM_W-1:0];
    weight_next = w[REM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      y_q         <= 1'b0;
      done_q      <= 1'b0;
      frame_div_q <= 1'b0;
      frame_rem_q <= '0;
      weight_q    <= REM_W'(1);
`ifdef MODN_HIT_CNT_EN
      hit_cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (in_valid) begin
        rem_q    <= rem_next;
        y_q      <= (rem_next == '0);
        weight_q <= weight_next;
        if (in_last) begin
          state_q     <= StIdle;
          done_q      <= 1'b1;
          frame_rem_q <= rem_next;
          frame_div_q <= (rem_next == '0);
`ifdef MODN_HIT_CNT_EN
          if ((rem_next == '0) && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
`endif
        end else begin
          state_q <= StAccum;
        end
      end else if (clear) begin
        state_q  <= StIdle;
        rem_q    <= '0;
        y_q      <= 1'b0;
        weight_q <= REM_W'(1);
      end
    end
  end

  assign y         = y_q;
  assign rem       = rem_q;
  assign busy      = (state_q == StAccum);
  assign done      = done_q;
  assign frame_div = frame_div_q;
  assign frame_rem = frame_rem_q;
`ifdef MODN_HIT_CNT_EN
  assign hit_cnt   = hit_cnt_q;
`endif

endmodule

// File: tb/tb_modn_stream_checker.sv
// Bench for modn_stream_checker. Four instances with different configurations share one
// stimulus stream: A (5,1,MSB), B (7,4,MSB), C (3,1,LSB) and D (11,8,LSB).
module tb_modn_stream_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, clear = 1'b0;
  logic [7:0] bits = '0;
  int         vectors = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  logic       y_a, busy_a, done_a, fdiv_a;
  logic [2:0] rem_a, frem_a;
  logic       y_b, busy_b, done_b, fdiv_b;
  logic [2:0] rem_b, frem_b;
  logic       y_c, busy_c, done_c, fdiv_c;
  logic [1:0] rem_c, frem_c;
  logic       y_d, busy_d, done_d, fdiv_d;
  logic [3:0] rem_d, frem_d;
`ifdef MODN_HIT_CNT_EN
  logic [15:0] hit_a, hit_b, hit_c, hit_d;
`endif

  modn_stream_checker #(.DIVISOR(5), .W_IN(1), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(bits[0:0]), .in_last(in_last),
    .clear(clear),
`ifdef MODN_HIT_CNT_EN
    .hit_cnt(hit_a),
`endif
    .y(y_a), .rem(rem_a), .busy(busy_a), .done(done_a), .frame_div(fdiv_a), .frame_rem(frem_a)
  );
  modn_stream_checker #(.DIVISOR(7), .W_IN(4), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(bits[3:0]), .in_last(in_last),
    .clear(clear),
`ifdef MODN_HIT_CNT_EN
    .hit_cnt(hit_b),
`endif
    .y(y_b), .rem(rem_b), .busy(busy_b), .done(done_b), .frame_div(fdiv_b), .frame_rem(frem_b)
  );
  modn_stream_checker #(.DIVISOR(3), .W_IN(1), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(bits[0:0]), .in_last(in_last),
    .clear(clear),
`ifdef MODN_HIT_CNT_EN
    .hit_cnt(hit_c),
`endif
    .y(y_c), .rem(rem_c), .busy(busy_c), .done(done_c), .frame_div(fdiv_c), .frame_rem(frem_c)
  );
  modn_stream_checker #(.DIVISOR(11), .W_IN(8), .MSB_FIRST(1'b0)) u_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(bits), .in_last(in_last),
    .clear(clear),
`ifdef MODN_HIT_CNT_EN
    .hit_cnt(hit_d),
`endif
    .y(y_d), .rem(rem_d), .busy(busy_d), .done(done_d), .frame_div(fdiv_d), .frame_rem(frem_d)
  );

  // Output views indexed by instance: flags are {y, busy, done, frame_div}.
  logic [3:0] flag_v [4];
  logic [7:0] rem_v  [4];
  logic [7:0] frem_v [4];
  assign flag_v[0] = {y_a, busy_a, done_a, fdiv_a};
  assign flag_v[1] = {y_b, busy_b, done_b, fdiv_b};
  assign flag_v[2] = {y_c, busy_c, done_c, fdiv_c};
  assign flag_v[3] = {y_d, busy_d, done_d, fdiv_d};
  assign rem_v[0]  = 8'(rem_a);
  assign rem_v[1]  = 8'(rem_b);
  assign rem_v[2]  = 8'(rem_c);
  assign rem_v[3]  = 8'(rem_d);
  assign frem_v[0] = 8'(frem_a);
  assign frem_v[1] = 8'(frem_b);
  assign frem_v[2] = 8'(frem_c);
  assign frem_v[3] = 8'(frem_d);

  int div_p [4] = '{5, 7, 3, 11};
  int w_p   [4] = '{1, 4, 1, 8};
  bit msb_p [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  // Apply one cycle of stimulus, then sample 1 ns after the rising edge.
  task automatic drive(input bit v, input logic [7:0] b, input bit l, input bit c, input bit r);
    @(negedge clk);
    in_valid = v;
    bits     = b;
    in_last  = l;
    clear    = c;
    reset    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (flag_v[i] !== 4'b0 || rem_v[i] !== 8'd0 || frem_v[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_dut%0d: flags=%b rem=%0d frem=%0d, want 0000/0/0", i, flag_v[i],
                 rem_v[i], frem_v[i]);
      end
    end
  endtask

  task automatic test_msb_d5();
    bit b1 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int er [4] = '{1, 2, 0, 0};
    bit ey [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {7'd0, b1[i]}, i == 3, 1'b0, 1'b0);
      vectors++;
      if (rem_a !== 3'(er[i]) || {y_a, busy_a, done_a} !== {ey[i], eb[i], ed[i]}) begin
        errors++;
        $display("FAIL msb_d5_beat%0d: rem=%0d y/busy/done=%b, want rem=%0d y/busy/done=%b", i,
                 rem_a, {y_a, busy_a, done_a}, er[i], {ey[i], eb[i], ed[i]});
      end
    end
    vectors++;
    if (fdiv_a !== 1'b1 || frem_a !== 3'd0) begin
      errors++;
      $display("FAIL msb_d5_frame: fdiv=%b frem=%0d, want 1/0", fdiv_a, frem_a);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (done_a !== 1'b0 || rem_a !== 3'd0 || y_a !== 1'b1) begin
      errors++;
      $display("FAIL msb_d5_hold: done=%b rem=%0d y=%b, want 0/0/1", done_a, rem_a, y_a);
    end
  endtask

  task automatic test_multibit_d7();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rem_b !== 3'd3 || {y_b, busy_b, done_b} !== 3'b010) begin
      errors++;
      $display("FAIL d7_beat0: rem=%0d y/busy/done=%b, want 3/010", rem_b, {y_b, busy_b, done_b});
    end
    drive(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (rem_b !== 3'd4 || {y_b, busy_b, done_b, fdiv_b} !== 4'b0010 || frem_b !== 3'd4) begin
      errors++;
      $display("FAIL d7_last: rem=%0d flags=%b frem=%0d, want 4/0010/4", rem_b,
               {y_b, busy_b, done_b, fdiv_b}, frem_b);
    end
  endtask

  task automatic test_lsb_d3();
    bit b1 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int er [4] = '{1, 0, 0, 0};
    bit ey [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {7'd0, b1[i]}, i == 3, 1'b0, 1'b0);
      vectors++;
      if (rem_c !== 2'(er[i]) || y_c !== ey[i]) begin
        errors++;
        $display("FAIL lsb_d3_beat%0d: rem=%0d y=%b, want rem=%0d y=%b", i, rem_c, y_c, er[i],
                 ey[i]);
      end
    end
    vectors++;
    if (done_c !== 1'b1 || fdiv_c !== 1'b1 || frem_c !== 2'd0) begin
      errors++;
      $display("FAIL lsb_d3_frame: done=%b fdiv=%b frem=%0d, want 1/1/0", done_c, fdiv_c, frem_c);
    end
  endtask

  task automatic test_clear_with_beat();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rem_a !== 3'd3) begin
      errors++;
      $display("FAIL clrbeat_pre: rem=%0d, want 3", rem_a);
    end
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (rem_a !== 3'd1 || {y_a, busy_a, done_a} !== 3'b010) begin
      errors++;
      $display("FAIL clrbeat_restart: rem=%0d y/busy/done=%b, want 1/010", rem_a,
               {y_a, busy_a, done_a});
    end
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (rem_a !== 3'd2 || done_a !== 1'b1 || frem_a !== 3'd2 || fdiv_a !== 1'b0) begin
      errors++;
      $display("FAIL clrbeat_last: rem=%0d done=%b frem=%0d fdiv=%b, want 2/1/2/0", rem_a, done_a,
               frem_a, fdiv_a);
    end
  endtask

  task automatic test_midframe_reset();
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({y_a, busy_a, done_a, fdiv_a} !== 4'b0 || rem_a !== 3'd0 || frem_a !== 3'd0) begin
      errors++;
      $display("FAIL midreset: flags=%b rem=%0d frem=%0d, want 0000/0/0",
               {y_a, busy_a, done_a, fdiv_a}, rem_a, frem_a);
    end
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({busy_a, done_a, fdiv_a} !== 3'b011 || frem_a !== 3'd0) begin
      errors++;
      $display("FAIL midreset_single: busy/done/fdiv=%b frem=%0d, want 011/0",
               {busy_a, done_a, fdiv_a}, frem_a);
    end
  endtask

  task automatic test_clear_idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({y_a, busy_a, done_a, fdiv_a} !== 4'b0 || rem_a !== 3'd0 || frem_a !== 3'd1) begin
      errors++;
      $display("FAIL clear_alone: flags=%b rem=%0d frem=%0d, want 0000/0/1",
               {y_a, busy_a, done_a, fdiv_a}, rem_a, frem_a);
    end
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rem_a !== 3'd1 || rem_d !== 4'd1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL clear_restart: remA=%0d remD=%0d busy=%b, want 1/1/1", rem_a, rem_d, busy_a);
    end
    // D: 1 + 1*256 = 257 = 4 mod 11, so the weight must have restarted at 1.
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (rem_a !== 3'd3 || rem_d !== 4'd4 || done_d !== 1'b1 || frem_d !== 4'd4) begin
      errors++;
      $display("FAIL clear_frame: remA=%0d remD=%0d doneD=%b fremD=%0d, want 3/4/1/4", rem_a,
               rem_d, done_d, frem_d);
    end
  endtask

`ifdef MODN_HIT_CNT_EN
  task automatic test_hit_cnt();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (hit_a !== 16'd1) begin
      errors++;
      $display("FAIL hit_first: hit_cnt=%0d, want 1", hit_a);
    end
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (hit_a !== 16'd1) begin
      errors++;
      $display("FAIL hit_nondiv: hit_cnt=%0d, want 1", hit_a);
    end
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (hit_a !== 16'd2) begin
      errors++;
      $display("FAIL hit_third: hit_cnt=%0d, want 2", hit_a);
    end
    @(negedge clk);
    force u_a.hit_cnt_q = 16'hFFFF;
    #1;
    release u_a.hit_cnt_q;
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (hit_a !== 16'hFFFF) begin
      errors++;
      $display("FAIL hit_saturate: hit_cnt=%h, want ffff", hit_a);
    end
  endtask
`endif

  task automatic test_random();
    longint unsigned m_val [4];
    int              m_nb  [4];
    bit              m_busy[4], m_y[4], m_done[4], m_fdiv[4];
    int              m_rem [4], m_frem[4];
    int              fcnt;
    int              cnt_before;
    bit              v, l, c, r;
    logic [7:0]      b;
    longint unsigned beat;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0; m_nb[i] = 0; m_busy[i] = 0; m_y[i] = 0; m_done[i] = 0; m_fdiv[i] = 0;
      m_rem[i] = 0; m_frem[i] = 0;
    end
    fcnt = 0;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom % 64) == 0;
      v = ($urandom % 4) != 0;
      c = ($urandom % 12) == 0;
      b = 8'($urandom);
      l = v && (($urandom % 4) == 0);
      // Cap frames at 7 beats so the model's value fits in 64 bits.
      cnt_before = (!m_busy[0] || c) ? 0 : fcnt;
      if (v && cnt_before == 6) l = 1'b1;
      if (r) fcnt = 0;
      else if (v) fcnt = l ? 0 : cnt_before + 1;
      else if (c) fcnt = 0;
      drive(v, b, l, c, r);
      for (int i = 0; i < 4; i++) begin
        if (r) begin
          m_val[i] = 0; m_nb[i] = 0; m_busy[i] = 0; m_y[i] = 0; m_done[i] = 0; m_fdiv[i] = 0;
          m_rem[i] = 0; m_frem[i] = 0;
        end else begin
          m_done[i] = 0;
          if (v) begin
            if (!m_busy[i] || c) begin
              m_val[i] = 0;
              m_nb[i]  = 0;
            end
            beat = longint'(b) & ((64'd1 << w_p[i]) - 1);
            if (msb_p[i]) m_val[i] = (m_val[i] << w_p[i]) | beat;
            else m_val[i] = m_val[i] | (beat << m_nb[i]);
            m_nb[i] += w_p[i];
            m_rem[i] = int'(m_val[i] % longint'(div_p[i]));
            m_y[i]   = (m_rem[i] == 0);
            if (l) begin
              m_done[i] = 1; m_frem[i] = m_rem[i]; m_fdiv[i] = m_y[i]; m_busy[i] = 0;
            end else begin
              m_busy[i] = 1;
            end
          end else if (c) begin
            m_val[i] = 0; m_nb[i] = 0; m_rem[i] = 0; m_y[i] = 0; m_busy[i] = 0;
          end
        end
        vectors++;
        if (flag_v[i] !== {m_y[i], m_busy[i], m_done[i], m_fdiv[i]} ||
            rem_v[i] !== 8'(m_rem[i]) || frem_v[i] !== 8'(m_frem[i])) begin
          errors++;
          $display("FAIL rand_dut%0d_cyc%0d: flags=%b rem=%0d frem=%0d, want flags=%b rem=%0d frem=%0d",
                   i, n, flag_v[i], rem_v[i], frem_v[i],
                   {m_y[i], m_busy[i], m_done[i], m_fdiv[i]}, m_rem[i], m_frem[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_d5();
    test_multibit_d7();
    test_lsb_d3();
    test_clear_with_beat();
    test_midframe_reset();
    test_clear_idle();
`ifdef MODN_HIT_CNT_EN
    test_hit_cnt();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
